// File: rtl/seg7_scan_ctrl_pkg.sv
// rtl/seg7_scan_ctrl_pkg.sv - shared constants for the 7-segment scan controller
//
// Purpose: FSM state encoding, blank patterns and the anode select helper.
// Ports:   none (package).
package seg7_scan_ctrl_pkg;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_GAP   = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low one-cold anode pattern for digit index i.
  function automatic logic [3:0] an_onehot(input logic [1:0] i);
    logic [3:0] an;
    an    = AN_OFF;
    an[i] = 1'b0;
    return an;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_bcd_to_7seg.sv
// rtl/seg7_scan_ctrl_bcd_to_7seg.sv - BCD to active-low gfedcba segment decoder
//
// Purpose: combinational decode of one BCD nibble; nibbles above 9 are blank.
// Ports:   bcd (in, 4)  digit value
//          seg (out, 7) cathodes gfedcba, active low
module seg7_scan_ctrl_bcd_to_7seg
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed 4-digit common-anode display scanner
//
// Purpose: latches BCD digits + dp mask into a pending register, copies them to
//          the active register at each frame start (tear-free), and scans the
//          anodes with a blanking gap at the start of every digit slot.
// Config:  SEG7_LZB_EN - when defined, leading zeros on digits 3..1 are blanked.
// Ports:   i_clk, i_rst (async, active high)
//          i_digits[15:0] BCD digits, [3:0] = rightmost; i_dp_mask[3:0] dp request
//          i_load capture strobe; i_enable scan enable
//          o_seg[6:0] gfedcba active low; o_dp active low; o_an[3:0] active low
//          o_digit_sel[1:0] digit index of the current slot
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int GAP_CYCLES  = 1_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_dp_mask,
  input  logic        i_load,
  input  logic        i_enable,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [3:0]  o_an,
  output logic [1:0]  o_digit_sel
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  // Every slot starts here; with no gap the slot is lit from its first cycle.
  localparam logic [1:0] ST_START = (GAP_CYCLES == 0) ? ST_DRIVE : ST_GAP;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   pend_digits, act_digits;
  logic [3:0]    pend_dp, act_dp;

  // First cycle of a digit-0 slot: active is reloaded from pending.
  logic copy_now;
  assign copy_now = (state != ST_OFF) && (cnt == '0) && (idx == 2'd0);

  // Bypass so the output registered on the copy cycle already shows the new
  // frame (matters when the slot is lit from its first cycle).
  logic [15:0] cur_digits;
  logic [3:0]  cur_dp;
  assign cur_digits = copy_now ? pend_digits : act_digits;
  assign cur_dp     = copy_now ? pend_dp     : act_dp;

  logic [3:0] nibble;
  logic [6:0] dec_seg;
  assign nibble = cur_digits[{idx, 2'b00} +: 4];

  seg7_scan_ctrl_bcd_to_7seg u_dec (
    .bcd (nibble),
    .seg (dec_seg)
  );

  logic lzb_blank;
`ifdef SEG7_LZB_EN
  always_comb begin
    lzb_blank = 1'b0;
    case (idx)
      2'd3:    lzb_blank = (cur_digits[15:12] == 4'd0);
      2'd2:    lzb_blank = (cur_digits[15:8]  == 8'd0);
      2'd1:    lzb_blank = (cur_digits[15:4]  == 12'd0);
      default: lzb_blank = 1'b0;
    endcase
  end
`else
  assign lzb_blank = 1'b0;
`endif

  // Gating with i_enable darkens the pins on the same edge that leaves DRIVE.
  logic drive_now, sel_now;
  assign drive_now = i_enable && (state == ST_DRIVE);
  assign sel_now   = i_enable && (state != ST_OFF);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_OFF;
      cnt   <= '0;
      idx   <= 2'd0;
    end else if (!i_enable) begin
      state <= ST_OFF;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      case (state)
        ST_OFF: begin
          state <= ST_START;
          cnt   <= '0;
          idx   <= 2'd0;
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) state <= ST_DRIVE;
          cnt <= cnt + CW'(1);
        end
        ST_DRIVE: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            idx   <= idx + 2'd1;
            state <= ST_START;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
    end else begin
      // A load coinciding with the copy lands in pending; active gets the old one.
      if (i_load) begin
        pend_digits <= i_digits;
        pend_dp     <= i_dp_mask;
      end
      if (copy_now) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_seg       <= SEG_BLANK;
      o_dp        <= 1'b1;
      o_an        <= AN_OFF;
      o_digit_sel <= 2'd0;
    end else begin
      o_an        <= drive_now ? an_onehot(idx) : AN_OFF;
      o_seg       <= (drive_now && !lzb_blank) ? dec_seg : SEG_BLANK;
      o_dp        <= drive_now ? ~cur_dp[idx] : 1'b1;
      o_digit_sel <= sel_now ? idx : 2'd0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl (two geometries)
module tb_seg7_scan_ctrl;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] sel;
  } exp_t;

  localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] digits;
  logic [3:0]  dp;

  logic [6:0] seg_o [2];
  logic       dp_o  [2];
  logic [3:0] an_o  [2];
  logic [1:0] sel_o [2];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.REFRESH_DIV(8), .GAP_CYCLES(2)) u0 (
    .i_clk(clk), .i_rst(rst), .i_digits(digits), .i_dp_mask(dp),
    .i_load(load), .i_enable(en),
    .o_seg(seg_o[0]), .o_dp(dp_o[0]), .o_an(an_o[0]), .o_digit_sel(sel_o[0])
  );

  seg7_scan_ctrl #(.REFRESH_DIV(4), .GAP_CYCLES(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_digits(digits), .i_dp_mask(dp),
    .i_load(load), .i_enable(en),
    .o_seg(seg_o[1]), .o_dp(dp_o[1]), .o_an(an_o[1]), .o_digit_sel(sel_o[1])
  );

  // Reference model: pos = cycles elapsed since the scan (re)started, -1 when dark.
  int          rd [2] = '{8, 4};
  int          gp [2] = '{2, 0};
  int          pos [2] = '{-1, -1};
  logic [15:0] frame_d  [2];
  logic [3:0]  frame_dp [2];
  logic [15:0] mpend;
  logic [3:0]  mpend_dp;
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic [6:0] ref_seg(input logic [15:0] d, input int k);
    logic [15:0] sh;
    int v;
    sh = d >> (4 * k);
    v  = int'(sh[3:0]);
    if (v > 9) return 7'h7F;
`ifdef SEG7_LZB_EN
    if (k > 0 && sh == 16'd0) return 7'h7F;
`endif
    return GLYPH[v];
  endfunction

  function automatic exp_t model(input int i);
    exp_t e;
    int slot, p;
    e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, sel: 2'd0};
    if (rst) begin
      pos[i] = -1;
      return e;
    end
    if (pos[i] >= 0) begin
      if (pos[i] % (4 * rd[i]) == 0) begin
        frame_d[i]  = mpend;
        frame_dp[i] = mpend_dp;
      end
      if (en) begin
        slot  = (pos[i] / rd[i]) % 4;
        p     = pos[i] % rd[i];
        e.sel = 2'(slot);
        if (p >= gp[i]) begin
          e.an[slot] = 1'b0;
          e.seg      = ref_seg(frame_d[i], slot);
          e.dp       = ~frame_dp[i][slot];
        end
      end
    end
    pos[i] = en ? pos[i] + 1 : -1;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e0, e1;
    e0 = model(0);
    e1 = model(1);
    if (rst) begin
      mpend    = 16'd0;
      mpend_dp = 4'd0;
    end else if (load) begin
      mpend    = digits;
      mpend_dp = dp;
    end
    q0.push_back(e0);
    q1.push_back(e1);
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s[%0d] got %h want %h at %0t", name, inst, act, want, $time);
  endtask

  task automatic cmp(input int i, input exp_t e);
    chk("o_an", i, 32'(an_o[i]), 32'(e.an));
    chk("o_seg", i, 32'(seg_o[i]), 32'(e.seg));
    chk("o_dp", i, 32'(dp_o[i]), 32'(e.dp));
    chk("o_digit_sel", i, 32'(sel_o[i]), 32'(e.sel));
  endtask

  always @(negedge clk) begin
    if (q0.size() == 0 || q1.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty got %0d/%0d want >0 at %0t", q0.size(), q1.size(), $time);
    end else begin
      cmp(0, q0.pop_front());
      cmp(1, q1.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_lit0();
    for (int k = 0; k < 64 && an_o[0] == 4'hF; k++) tick();
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int k = 0; k < 4; k++)
      d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; digits = 16'd0; dp = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    digits = 16'h1234; dp = 4'b0000; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    repeat (70) tick();
    for (int k = 0; k < 64 && sel_o[0] != 2'd2; k++) tick();
    digits = 16'h9999; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (70) tick();
    digits = 16'h00A5; dp = 4'b0010; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (70) tick();
    wait_lit0();
    en = 1'b0;
    repeat (10) tick();
    en = 1'b1;
    repeat (40) tick();
    wait_lit0();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    digits = 16'h0708; dp = 4'b0101; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (40) tick();
    repeat (3000) begin
      load = ($urandom_range(0, 99) < 8);
      if (load) begin
        digits = rand_digits();
        dp     = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 3) == 0) begin
        digits = rand_digits();
      end
      if ($urandom_range(0, 99) < 2) en = ~en;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; load = 1'b0;
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
